// File: rtl/hex7seg_scan_driver.sv
// ============================================================================
// Module      : hex7seg_scan_driver
// Description : Time-multiplexed driver for DIGITS seven-segment digits.
//               A refresh prescaler advances a digit index; the selected
//               nibble of the active display register is decoded to a
//               segment pattern and driven together with its decimal point
//               and a one-hot digit enable. New data is held in a pending
//               register and only swapped into the display at a frame
//               boundary, so a frame never mixes old and new digits.
//
// Parameters  : DIGITS          number of scanned digits (1..8)
//               DIV_W           prescaler width; slot = 2^DIV_W enabled cycles
//               SEG_ACTIVE_LOW  1 inverts seg and dp
//               AN_ACTIVE_LOW   1 inverts an
//
// Ports       : clk         system clock
//               rst_n       asynchronous active-low reset
//               ena         enable; low freezes scan, outputs inactive
//               data_in     4*DIGITS nibbles, digit 0 in bits 3:0
//               dp_in       decimal point per digit
//               load        strobe capturing data_in/dp_in as pending data
//               blank       forces seg/dp/an inactive, scan keeps running
//               seg         segments a..g on bits 0..6 (registered)
//               dp          decimal point of the active digit (registered)
//               an          one-hot digit enable (registered)
//               frame_done  one-cycle pulse after the scan wraps to digit 0
//               pending     loaded data waiting for the next frame boundary
//
// Options     : HEX7SEG_LZB_EN  when defined, digits above digit 0 whose
//                               nibble and all more significant nibbles are
//                               zero show no segments (leading-zero blanking)
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex7seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int DIV_W          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DIGITS - 1);
    // Physical "off" levels of the output pins for the chosen polarity.
    localparam logic [6:0]        C_SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic              C_DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] C_AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]    div_q,       div_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q,   disp_dp_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q,   pend_dp_d;
    logic                pending_q,   pending_d;
    logic                frame_done_q, frame_done_d;
    logic [6:0]          seg_q,       seg_d;
    logic                dp_q,        dp_d;
    logic [DIGITS-1:0]   an_q,        an_d;

    logic                tick;
    logic                boundary;
    logic [DIGITS-1:0]   lz_mask;

    // ------------------------------------------------------------------------
    // Hex to segment decode, active-high, bit 0 = segment a
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Leading-zero mask: bit k set when digit k must show no segments
    // ------------------------------------------------------------------------
`ifdef HEX7SEG_LZB_EN
    // zero_from[k]: nibble k and every more significant nibble are zero.
    logic [DIGITS-1:0] zero_from;

    for (genvar k = 0; k < DIGITS; k++) begin : g_zero_from
        if (k == DIGITS - 1) begin : g_top
            assign zero_from[k] = (disp_data_q[4*k +: 4] == 4'h0);
        end else begin : g_lower
            assign zero_from[k] = (disp_data_q[4*k +: 4] == 4'h0) && zero_from[k+1];
        end
    end

    // Digit 0 always shows its value so a zero display reads "0".
    assign lz_mask = zero_from & ~DIGITS'(1);
`else
    assign lz_mask = '0;
`endif

    // ------------------------------------------------------------------------
    // Prescaler, scan index and data registers
    // ------------------------------------------------------------------------
    always_comb begin
        tick     = ena && (&div_q);
        boundary = tick && (idx_q == C_LAST_IDX);

        div_d = ena ? div_q + 1'b1 : div_q;

        idx_d = idx_q;
        if (tick) begin
            // Explicit wrap so non-power-of-two digit counts skip unused codes.
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pending_d    = pending_q;
        frame_done_d = boundary;

        if (load && boundary) begin
            // Arriving exactly at the boundary: nothing to wait for.
            disp_data_d = data_in;
            disp_dp_d   = dp_in;
            pending_d   = 1'b0;
        end else if (load) begin
            // A later load simply overwrites an earlier unapplied one.
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pending_d   = 1'b1;
        end else if (boundary && pending_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            pending_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output pattern for the current digit
    // ------------------------------------------------------------------------
    always_comb begin
        logic [3:0]        nib;
        logic              dp_sel;
        logic              lz_sel;
        logic [DIGITS-1:0] onehot;
        logic [6:0]        seg_log;

        nib    = 4'h0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib       = disp_data_q[4*k +: 4];
                dp_sel    = disp_dp_q[k];
                lz_sel    = lz_mask[k];
                onehot[k] = 1'b1;
            end
        end

        seg_log = lz_sel ? 7'h00 : hex_to_seg(nib);

        if (blank || !ena) begin
            seg_log = 7'h00;
            dp_sel  = 1'b0;
            onehot  = '0;
        end

        seg_d = seg_log ^ C_SEG_OFF;
        dp_d  = dp_sel  ^ C_DP_OFF;
        an_d  = onehot  ^ C_AN_OFF;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= C_SEG_OFF;
            dp_q         <= C_DP_OFF;
            an_q         <= C_AN_OFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

`default_nettype wire

// File: doc/hex7seg_scan_driver.md
# hex7seg_scan_driver

Time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits, decoding DIGITS hexadecimal nibbles to segment patterns and scanning one digit at a time. It is the parametrised successor of the single-digit combinational hex decoder. It adds a refresh prescaler, digit scanning, per-digit decimal points and tear-free frame-synchronous data update. It sits between the user datapath and the uo_out/uio_out pad wrapper.

## Interface
- DIGITS, 4, number of scanned digits (1..8)
- DIV_W, 16, prescaler width; one digit slot = 2^DIV_W enabled cycles
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp outputs
- AN_ACTIVE_LOW, 0, 1 inverts an outputs

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes scan and forces outputs inactive
- data_in  in  4*DIGITS  nibble k (bits 4k+3:4k) = digit k; digit 0 least significant
- dp_in  in  DIGITS  decimal point per digit
- load  in  1  one-cycle strobe; captures data_in/dp_in into pending register
- blank  in  1  forces seg, dp, an inactive; scan keeps running
- seg  out  7  segments, seg[0]=a … seg[6]=g, registered
- dp  out  1  decimal point of active digit, registered
- an  out  DIGITS  one-hot digit enable, registered
- frame_done  out  1  one-cycle pulse when scan wraps from DIGITS-1 to 0
- pending  out  1  high while loaded data awaits the next frame boundary

## Operation
- Prescaler: DIV_W-bit counter, increments when ena=1; tick = counter all ones.
- Digit index: 0..DIGITS-1, advances on tick, wraps DIGITS-1 -> 0 (non-power-of-two DIGITS wraps at DIGITS-1, never visits unused codes).
- Registers: display (active), pend_reg, pending flag.
- load: pend_reg <= {dp_in, data_in}, pending <= 1. A second load before the boundary overwrites pend_reg; only the last value is shown.
- Frame boundary = tick while index = DIGITS-1: frame_done pulses; if pending, display <= pend_reg and pending <= 0.
- load coincident with frame boundary: data_in/dp_in go straight to display, pending stays/clears to 0.
- Decode (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Outputs each cycle: seg <= decode(display nibble[index]); dp <= display dp[index]; an <= onehot(index); then polarity params applied.
- blank=1 or ena=0: seg=0, dp=0, an=0 (logical, before polarity).

## Timing
- Reset (rst_n=0, asynchronous): prescaler 0, index 0, display 0, pend_reg 0, pending 0, frame_done 0, seg/dp/an logically inactive (physical level per polarity params).
- Output latency: 1 cycle from index/display/blank/ena change to seg/dp/an.
- Digit slot: exactly 2^DIV_W enabled cycles; frame: DIGITS*2^DIV_W enabled cycles.
- frame_done: asserted the cycle after the boundary tick, for one cycle.
- pending: rises the cycle after load, falls the cycle after the boundary that applies it.
- ena low mid-slot: counter and index hold; resume exactly where stopped.
- Reset mid-frame: all state cleared immediately; pending data discarded.

## Configuration
- HEX7SEG_LZB_EN (leading-zero blanking). Defined: any digit k>0 whose nibble and all more significant nibbles are 0 shows seg=0. Its an and dp are still driven normally. Digit 0 is never blanked. Undefined: all digits decoded, zeros shown as 3F.

## Test plan
- Reset: rst_n=0 with clk running -> seg=0, dp=0, an=0, pending=0; after release with ena=1, one cycle later an=0001, seg=3F.
- DIGITS=4, DIV_W=2: load 16'h1A3F at boundary -> slots show 71, 4F, 77, 06 on an 0001, 0010, 0100, 1000. Each slot lasts 4 cycles, then frame_done pulses.
- Load 16'h1234 mid-frame -> pending=1, current frame unchanged; next frame shows 1234, pending=0.
- Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222.
- ena=0 for 10 cycles mid-slot -> outputs inactive, index frozen. blank=1 -> outputs inactive, frame_done period unchanged.
- HEX7SEG_LZB_EN defined, display 16'h0050 -> digits 3,2 seg=0; digit 1 = 6D; digit 0 = 3F. Undefined -> 3F,3F,6D,3F.
